addsub_arbiter: RTL and testbench

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

---
 rtl/addsub_arbiter.sv | 157 +++++++++++++++
 tb/tb_addsub_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end for a shared 32-bit add/sub datapath.
// One operation in flight; the result is captured after a fixed settle time.
module addsub_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  output logic        req1_ready,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  output logic        dp_sub,
  input  logic [31:0] dp_ans,
  input  logic        dp_cout,
  input  logic        dp_v,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_ans,
  output logic        resp_cout,
  output logic        resp_v,
  output logic        busy,
  output logic [15:0] ovf_count
);

  typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] dp_a_q, dp_a_d;
  logic [31:0] dp_b_q, dp_b_d;
  logic        dp_sub_q, dp_sub_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_id_q, resp_id_d;
  logic [31:0] resp_ans_q, resp_ans_d;
  logic        resp_cout_q, resp_cout_d;
  logic        resp_v_q, resp_v_d;
  logic [15:0] ovf_q, ovf_d;

  logic gnt0, gnt1;

  // On a tie the requester that was not served last wins.
  always_comb begin
    gnt0 = req0_valid && (!req1_valid || last_grant_q);
    gnt1 = req1_valid && (!req0_valid || !last_grant_q);
  end

  assign req0_ready = (state_q == StIdle) && !rst && gnt0;
  assign req1_ready = (state_q == StIdle) && !rst && gnt1;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    dp_sub_d     = dp_sub_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_ans_d   = resp_ans_q;
    resp_cout_d  = resp_cout_q;
    resp_v_d     = resp_v_q;
    ovf_d        = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (gnt0 || gnt1) begin
          dp_a_d       = gnt1 ? req1_a   : req0_a;
          dp_b_d       = gnt1 ? req1_b   : req0_b;
          dp_sub_d     = gnt1 ? req1_sub : req0_sub;
          last_grant_d = gnt1;
          owner_d      = gnt1;
          cnt_d        = 4'(SETTLE_CYCLES);
          state_d      = StSettle;
        end
      end
      StSettle: begin
        cnt_d = cnt_q - 4'd1;
        // <= 1 also recovers if the counter was ever left at zero.
        if (cnt_q <= 4'd1) begin
          cnt_d        = 4'd0;
          resp_ans_d   = dp_ans;
          resp_cout_d  = dp_cout;
          resp_v_d     = dp_v;
          resp_id_d    = owner_q;
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end
      end
      StResp: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          if (resp_v_q && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= 4'd0;
      dp_a_q       <= 32'd0;
      dp_b_q       <= 32'd0;
      dp_sub_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_ans_q   <= 32'd0;
      resp_cout_q  <= 1'b0;
      resp_v_q     <= 1'b0;
      ovf_q        <= 16'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      dp_sub_q     <= dp_sub_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_ans_q   <= resp_ans_d;
      resp_cout_q  <= resp_cout_d;
      resp_v_q     <= resp_v_d;
      ovf_q        <= ovf_d;
    end
  end

  assign dp_a       = dp_a_q;
  assign dp_b       = dp_b_q;
  assign dp_sub     = dp_sub_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_ans   = resp_ans_q;
  assign resp_cout  = resp_cout_q;
  assign resp_v     = resp_v_q;
  assign busy       = (state_q != StIdle);
  assign ovf_count  = ovf_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: directed spec scenarios, then random operations checked
// against a transaction-level model of grant order, arithmetic and overflow count.
module tb_addsub_arbiter;

  localparam int unsigned SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_sub, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_sub, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [31:0] dp_a, dp_b, dp_ans;
  logic        dp_sub, dp_cout, dp_v;
  logic        resp_valid, resp_ready, resp_id, resp_cout, resp_v, busy;
  logic [31:0] resp_ans;
  logic [15:0] ovf_count;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state.
  bit          last_m;
  int unsigned ovf_m;

  always #5 clk = ~clk;

  addsub_arbiter #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .req1_ready(req1_ready),
    .dp_a(dp_a), .dp_b(dp_b), .dp_sub(dp_sub),
    .dp_ans(dp_ans), .dp_cout(dp_cout), .dp_v(dp_v),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_ans(resp_ans), .resp_cout(resp_cout), .resp_v(resp_v),
    .busy(busy), .ovf_count(ovf_count)
  );

  // External datapath: A + (B or ~B) + SUB.
  logic [32:0] dp_sum;
  logic [31:0] dp_bb;
  always_comb begin
    dp_bb   = dp_sub ? ~dp_b : dp_b;
    dp_sum  = {1'b0, dp_a} + {1'b0, dp_bb} + {32'd0, dp_sub};
    dp_ans  = dp_sum[31:0];
    dp_cout = dp_sum[32];
    dp_v    = (dp_a[31] == dp_bb[31]) && (dp_sum[31] != dp_a[31]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_ans(input logic [31:0] a, b, input bit s);
    return s ? a - b : a + b;
  endfunction

  function automatic bit exp_cout(input logic [31:0] a, b, input bit s);
    longint unsigned t;
    if (s) return a >= b;
    t = longint'(a) + longint'(b);
    return t > 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic bit exp_v(input logic [31:0] a, b, input bit s);
    longint r;
    r = s ? longint'($signed(a)) - longint'($signed(b))
          : longint'($signed(a)) + longint'($signed(b));
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tick();
    check("ready0_in_rst", {31'd0, req0_ready}, 32'd0);
    check("ready1_in_rst", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    last_m = 1'b1;
    ovf_m  = 0;
  endtask

  // One full transaction: present requests, check grant, latency, result, backpressure
  // for `hold` cycles, handshake and overflow count.
  task automatic run_op(input bit v0, input logic [31:0] a0, b0, input bit s0,
                        input bit v1, input logic [31:0] a1, b1, input bit s1,
                        input int hold);
    bit          win;
    logic [31:0] ea, eb;
    bit          es, stable;
    int          lat;
    logic [31:0] sans;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
    resp_ready = 1'b0;
    #1;
    win = (v0 && v1) ? ~last_m : !v0;
    ea = win ? a1 : a0;
    eb = win ? b1 : b0;
    es = win ? s1 : s0;
    check("grant_ready0", {31'd0, req0_ready}, {31'd0, !win});
    check("grant_ready1", {31'd0, req1_ready}, {31'd0, win});
    tick();
    // Operands are sampled only at accept; scramble them while settling.
    req0_a = $urandom; req0_b = $urandom; req0_sub = $urandom_range(0, 1);
    req1_a = $urandom; req1_b = $urandom; req1_sub = $urandom_range(0, 1);
    check("busy_settle", {31'd0, busy}, 32'd1);
    check("dp_a", dp_a, ea);
    check("dp_b", dp_b, eb);
    check("dp_sub", {31'd0, dp_sub}, {31'd0, es});
    lat = 0;
    while (!resp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", lat, SETTLE);
    check("resp_id", {31'd0, resp_id}, {31'd0, win});
    check("resp_ans", resp_ans, exp_ans(ea, eb, es));
    check("resp_cout", {31'd0, resp_cout}, {31'd0, exp_cout(ea, eb, es)});
    check("resp_v", {31'd0, resp_v}, {31'd0, exp_v(ea, eb, es)});
    sans = resp_ans;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!resp_valid || resp_ans !== sans || req0_ready || req1_ready || !busy)
        stable = 1'b0;
    end
    if (hold > 0) check("backpressure_stable", {31'd0, stable}, 32'd1);
    check("ovf_before_hs", {16'd0, ovf_count}, ovf_m);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    if (exp_v(ea, eb, es) && ovf_m < 65535) ovf_m++;
    last_m = win;
    check("ovf_after_hs", {16'd0, ovf_count}, ovf_m);
    check("resp_valid_clr", {31'd0, resp_valid}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    bit          v0, v1;
    int          lat;
    rst = 1'b1; resp_ready = 1'b0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_sub = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_sub = 0;
    tick();
    do_reset();
    check("rst_dp_a", dp_a, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_ans", resp_ans, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf", {16'd0, ovf_count}, 32'd0);

    // Single add on requester 0.
    run_op(1, 32'h21, 32'h22, 0, 0, 32'h0, 32'h0, 0, 0);
    check("add_ans_literal", resp_ans, 32'h43);

    // Tie sequence right after reset: req0, req1, then req0 again.
    do_reset();
    run_op(1, 32'h336FB7E5, 32'h336FB7E5, 1, 1, 32'hFFFFFFFF, 32'h13B72214, 1, 0);
    check("tie1_ans_literal", resp_ans, 32'h0);
    run_op(1, 32'h336FB7E5, 32'h336FB7E5, 1, 1, 32'hFFFFFFFF, 32'h13B72214, 1, 0);
    check("tie2_ans_literal", resp_ans, 32'hEC48DDEB);
    run_op(1, 32'h1, 32'h2, 0, 1, 32'h3, 32'h4, 0, 0);
    check("tie3_id_literal", {31'd0, resp_id}, 32'd0);

    // Signed overflow on requester 1.
    run_op(0, 32'h0, 32'h0, 0, 1, 32'h7FFFFFFF, 32'h1, 0, 2);
    check("ovf_literal", {16'd0, ovf_count}, 32'd1);

    // Backpressure with both requesters valid.
    run_op(1, 32'h80000000, 32'h1, 1, 1, 32'h12345678, 32'h9ABCDEF0, 0, 10);

    // Random operations.
    for (int n = 0; n < 24; n++) begin
      v0 = $urandom_range(0, 1);
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      run_op(v0, $urandom, $urandom, 1'($urandom_range(0, 1)),
             v1, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    // Reset two edges after an accept abandons the operation.
    req1_valid = 1'b1; req1_a = 32'hDEADBEEF; req1_b = 32'h1; req1_sub = 1'b0;
    tick();
    req1_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_m = 1'b1;
    ovf_m  = 0;
    lat = 0;
    for (int i = 0; i < 2 * SETTLE; i++) begin
      if (resp_valid) lat++;
      tick();
    end
    check("abandon_no_resp", lat, 0);
    check("abandon_dp_a", dp_a, 32'd0);
    check("abandon_ovf", {16'd0, ovf_count}, 32'd0);
    check("abandon_busy", {31'd0, busy}, 32'd0);
    run_op(1, 32'h5, 32'h6, 1, 1, 32'h7, 32'h8, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
